// File: rtl/reg32_scan_reader_pkg.sv
// Shared types and constants for the register-bank scan reader.
// Build option: SCAN_CHECKSUM_EN appends an XOR checksum word to each scan.
package reg32_scan_reader_pkg;

  localparam int WORD_W    = 32;
  localparam int IDX_W_DEF = 6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Words per scan: the registers, plus the checksum word when it is built in.
  function automatic int num_words(input int n_regs);
`ifdef SCAN_CHECKSUM_EN
    return n_regs + 1;
`else
    return n_regs;
`endif
  endfunction

endpackage

// File: rtl/reg32_scan_reader_if.sv
// Valid/ready word stream carrying the scanned bank image.
// Build option: SCAN_CHECKSUM_EN (index range grows by one).
interface reg32_scan_reader_if #(
  parameter int IDX_W = 6
);
  import reg32_scan_reader_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [IDX_W-1:0]  out_index;

  modport master (
    output out_data, out_valid, out_last, out_index,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_last, out_index,
    output out_ready
  );

endinterface

// File: rtl/reg32_snapshot.sv
// Capture array for the bank image with load enable and word-select mux.
// Build option: SCAN_CHECKSUM_EN stores the XOR of all words as an extra entry.
module reg32_snapshot
  import reg32_scan_reader_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       i_load,
  input  logic [NUM_REGS*WORD_W-1:0] i_reg_q,
  input  logic [IDX_W-1:0]           i_sel,
  output logic [WORD_W-1:0]          o_word
);

  localparam int NUM_WORDS = num_words(NUM_REGS);

  logic [NUM_WORDS-1:0][WORD_W-1:0] r_mem;
  logic [NUM_WORDS-1:0][WORD_W-1:0] w_cap;

`ifdef SCAN_CHECKSUM_EN
  logic [WORD_W-1:0] w_sum;

  // Checksum is taken from the same sample as the words, so it always matches the image.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_REGS; k++) w_sum = w_sum ^ i_reg_q[k*WORD_W +: WORD_W];
  end

  assign w_cap = {w_sum, i_reg_q};
`else
  assign w_cap = i_reg_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_mem <= '0;
    else if (i_load) r_mem <= w_cap;
  end

  always_comb begin
    o_word = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      if (i_sel == IDX_W'(k)) o_word = r_mem[k];
  end

endmodule

// File: rtl/reg32_scan_reader.sv
// Snapshots the register bank on start and streams it one word per handshake.
// Build option: SCAN_CHECKSUM_EN streams an XOR checksum as the final word.
module reg32_scan_reader
  import reg32_scan_reader_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REGS*WORD_W-1:0] reg_q,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  reg32_scan_reader_if.master        out_if
);

  localparam int               NUM_WORDS = num_words(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_done, w_done_nxt;
  logic              w_load;
  logic              w_hs;
  logic              w_stream;
  logic [WORD_W-1:0] w_word;

  reg32_snapshot #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_snap (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_reg_q (reg_q),
    .i_sel   (r_idx),
    .o_word  (w_word)
  );

  assign w_stream = (r_state == ST_STREAM);
  assign w_hs     = w_stream && out_if.out_ready;

  // start is only looked at in IDLE, so requests during a scan are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_STREAM;
          w_load      = 1'b1;
          w_idx_nxt   = '0;
        end
      end
      ST_STREAM: begin
        if (w_hs) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy             = w_stream;
  assign done             = r_done;
  assign out_if.out_valid = w_stream;
  assign out_if.out_last  = w_stream && (r_idx == LAST_IDX);
  assign out_if.out_index = r_idx;
  // Data is forced to zero outside a scan so an idle bus never shows stale image.
  assign out_if.out_data  = w_stream ? w_word : '0;

endmodule

// File: tb/tb_reg32_scan_reader.sv
// Self-checking bench for reg32_scan_reader: vector table, corner sequences, random scans.
// Follows SCAN_CHECKSUM_EN to decide the expected scan length.
module tb_reg32_scan_reader;
  import reg32_scan_reader_pkg::*;

  localparam int NR = 4;
  localparam int IW = 6;
`ifdef SCAN_CHECKSUM_EN
  localparam int NW = NR + 1;
`else
  localparam int NW = NR;
`endif

  logic            clock   = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic [NR*32-1:0] reg_q  = '0;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [NR*32-1:0] img;
    logic [31:0]      rdy;
    int               scr;
    bit               poke;
    logic [31:0]      exp_top;
    logic [31:0]      exp_ck;
  } vec_t;
  vec_t tbl[$];

  reg32_scan_reader_if #(.IDX_W(IW)) bus();

  reg32_scan_reader #(.NUM_REGS(NR), .IDX_W(IW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .reg_q   (reg_q),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .out_if  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stream is the words captured at start, optionally followed by their XOR.
  task automatic model_load(input logic [NR*32-1:0] img);
    logic [31:0] ck;
    ck = '0;
    exp_q.delete();
    for (int k = 0; k < NR; k++) begin
      exp_q.push_back(img[k*32 +: 32]);
      ck ^= img[k*32 +: 32];
    end
`ifdef SCAN_CHECKSUM_EN
    exp_q.push_back(ck);
`endif
  endtask

  function automatic logic [NR*32-1:0] rand_img();
    logic [NR*32-1:0] v;
    for (int k = 0; k < NR; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic add(input logic [NR*32-1:0] img, input logic [31:0] rdy, input int scr,
                     input bit poke, input logic [31:0] top, input logic [31:0] ck);
    vec_t v;
    v.img = img; v.rdy = rdy; v.scr = scr; v.poke = poke; v.exp_top = top; v.exp_ck = ck;
    tbl.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  // scr: 0 keep reg_q, 1 force all-ones after capture, 2 randomize every cycle.
  task automatic run_scan(input logic [NR*32-1:0] img, input logic [31:0] rdy_pat, input bit rnd_rdy,
                          input bit poke, input int scr, output logic [31:0] fin);
    int hs  = 0;
    int cyc = 0;
    fin = '0;
    model_load(img);
    reg_q = img;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    if (scr == 1) reg_q = '1;
    chk("latency_valid", bus.out_valid, 1);
    chk("latency_busy", busy, 1);
    while (hs < NW && cyc < 400) begin
      chk("valid", bus.out_valid, 1);
      chk("index", bus.out_index, hs);
      chk("data", bus.out_data, exp_q[hs]);
      chk("last", bus.out_last, (hs == NW - 1));
      chk("done_low", done, 0);
      if (hs == NW - 1) fin = bus.out_data;
      bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_pat[cyc % 32];
      start = poke;
      if (scr == 2) reg_q = rand_img();
      if (bus.out_ready) hs++;
      cyc++;
      @(negedge clock);
    end
    if (hs < NW) chk("scan_timeout", hs, NW);
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", bus.out_valid, 0);
    chk("last_after", bus.out_last, 0);
    chk("index_after", bus.out_index, 0);
  endtask

  task automatic idle_check();
    @(negedge clock);
    chk("done_single", done, 0);
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fin;
    logic [NR*32-1:0] img;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_index", bus.out_index, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    add({32'hD3, 32'hC2, 32'hB1, 32'hA0}, 32'hFFFF_FFFF, 0, 0, 32'hD3, 32'h0);
    add({32'h8, 32'h4, 32'h2, 32'h1}, 32'hFFFF_FFFF, 1, 0, 32'h8, 32'hF);
    add({32'h8888_8888, 32'h4444_4444, 32'h2222_2222, 32'h1111_1111}, 32'hAAAA_AAA9, 0, 0,
        32'h8888_8888, 32'hFFFF_FFFF);
    add({32'h0000_0080, 32'h0000_0040, 32'h0000_0020, 32'h0000_0010}, 32'hFFFF_FFFF, 0, 1,
        32'h0000_0080, 32'h0000_00F0);
    add({32'h0F00_0000, 32'h00F0_0000, 32'h000F_0000, 32'h0000_F000}, 32'h0000_00CB, 1, 1,
        32'h0F00_0000, 32'h0FFF_F000);

    for (int i = 0; i < tbl.size(); i++) begin
      run_scan(tbl[i].img, tbl[i].rdy, 1'b0, tbl[i].poke, tbl[i].scr, fin);
`ifdef SCAN_CHECKSUM_EN
      chk("tbl_final_word", fin, tbl[i].exp_ck);
`else
      chk("tbl_final_word", fin, tbl[i].exp_top);
`endif
      idle_check();
    end

    // Restart: start asserted in the done cycle begins the next scan immediately.
    run_scan({32'h44, 32'h33, 32'h22, 32'h11}, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, fin);
    run_scan({32'h99, 32'h88, 32'h77, 32'h66}, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, fin);
    idle_check();

    // Asynchronous reset in the middle of a scan.
    reg_q = {32'h4, 32'h3, 32'h2, 32'h1};
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("mid_index", bus.out_index, 2);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_last", bus.out_last, 0);
    chk("arst_done", done, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_index", bus.out_index, 0);
    @(negedge clock);
    chk("arst_no_done", done, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_done", done, 0);
    chk("post_rst_valid", bus.out_valid, 0);
    run_scan({32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001}, 32'hFFFF_FFFF,
             1'b0, 1'b0, 0, fin);
    idle_check();

    // Random images, random backpressure, bank churning during the stream.
    for (int n = 0; n < 25; n++) begin
      img = rand_img();
      run_scan(img, 32'h0, 1'b1, 1'($urandom_range(0, 1)), 2, fin);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
